// File: rtl/packet_ddr_writer.sv
// Receive-side packet buffer producer: packs TSE Avalon-ST bytes into 256-bit DDR
// words, writes payload then length word, and kicks the transmit stage with cmd_send.
module packet_ddr_writer #(
    parameter logic [24:0] BASE_ADDR      = 25'd16,
    parameter int          MAX_BYTES      = 255,
    parameter int          HOLDOFF_CYCLES = 2048
) (
    input  logic          clk_original,
    input  logic          rst,
    input  logic [7:0]    ff_rx_data,
    input  logic          ff_rx_dval,
    input  logic          ff_rx_sop,
    input  logic          ff_rx_eop,
    input  logic          ff_rx_err,
    output logic          ff_rx_rdy,
    output logic [24:0]   ram_address,
    output logic [255:0]  ram_wdata,
    output logic          ram_wren,
    input  logic          ram_ack,
    output logic          cmd_send,
    output logic [24:0]   start_ram_addr,
    output logic [15:0]   pkt_count,
    output logic [15:0]   drop_count
);

    // state   | meaning
    // IDLE    | waiting for a sop byte
    // COLLECT | packing frame bytes into the word register
    // WR_DATA | payload word write outstanding until ram_ack
    // WR_LEN  | length word write at BASE_ADDR outstanding until ram_ack
    // SEND    | cmd_send pulse, frame counted
    // HOLDOFF | transmit stage replaying; no new frame accepted
    // DISCARD | swallowing the rest of a rejected frame
    // DROP    | counting the drop and clearing frame state
    typedef enum logic [2:0] {
        IDLE, COLLECT, WR_DATA, WR_LEN, SEND, HOLDOFF, DISCARD, DROP
    } state_t;

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    state_t         state;
    logic [255:0]   word;
    logic [10:0]    count;
    logic [3:0]     word_idx;
    logic           last;
    logic [HW-1:0]  holdoff_cnt;

    logic           accept;
    logic [4:0]     pos;
    logic [7:0]     lsb;
    logic [255:0]   next_word;
    logic           at_max;

    assign start_ram_addr = BASE_ADDR;

    always_comb begin
        ff_rx_rdy = 1'b0;
        if (!rst && (state == IDLE || state == COLLECT || state == DISCARD))
            ff_rx_rdy = 1'b1;
    end

    assign accept = ff_rx_dval & ff_rx_rdy;

    // Byte k lands in lane 4*(k/4) + 3 - k%4, so byte 0 sits in bits [31:24].
    assign pos       = count[4:0];
    assign lsb       = {pos[4:2], ~pos[1:0], 3'b000};
    assign next_word = word | ({248'd0, ff_rx_data} << lsb);
    assign at_max    = (count == 11'(MAX_BYTES));

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            count       <= '0;
            word_idx    <= '0;
            last        <= 1'b0;
            holdoff_cnt <= '0;
            ram_address <= '0;
            ram_wdata   <= '0;
            ram_wren    <= 1'b0;
            cmd_send    <= 1'b0;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            cmd_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && ff_rx_sop) begin
                        count <= 11'd1;
                        word  <= next_word;
                        if (ff_rx_eop && ff_rx_err) begin
                            state <= DROP;
                        end else if (ff_rx_eop) begin
                            last        <= 1'b1;
                            ram_wren    <= 1'b1;
                            ram_address <= BASE_ADDR + 25'd1 + {21'd0, word_idx};
                            ram_wdata   <= next_word;
                            state       <= WR_DATA;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (ff_rx_eop && ff_rx_err) begin
                            state <= DROP;
                        end else if (at_max || ff_rx_sop) begin
                            state <= ff_rx_eop ? DROP : DISCARD;
                        end else begin
                            count <= count + 11'd1;
                            word  <= next_word;
                            if (ff_rx_eop || pos == 5'd31) begin
                                last        <= ff_rx_eop;
                                ram_wren    <= 1'b1;
                                ram_address <= BASE_ADDR + 25'd1 + {21'd0, word_idx};
                                ram_wdata   <= next_word;
                                state       <= WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (ram_wren && ram_ack) begin
                        ram_wren <= 1'b0;
                        word     <= '0;
                        word_idx <= word_idx + 4'd1;
                        state    <= last ? WR_LEN : COLLECT;
                    end
                end
                WR_LEN: begin
                    // One idle cycle after the last payload ack before the length write.
                    if (!ram_wren) begin
                        ram_wren    <= 1'b1;
                        ram_address <= BASE_ADDR;
                        ram_wdata   <= {245'd0, count};
                    end else if (ram_ack) begin
                        ram_wren <= 1'b0;
                        cmd_send <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    pkt_count   <= pkt_count + 16'd1;
                    count       <= '0;
                    word_idx    <= '0;
                    last        <= 1'b0;
                    word        <= '0;
                    holdoff_cnt <= HW'(HOLDOFF_CYCLES - 1);
                    state       <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (holdoff_cnt == '0)
                        state <= IDLE;
                    else
                        holdoff_cnt <= holdoff_cnt - 1'b1;
                end
                DISCARD: begin
                    if (accept && ff_rx_eop)
                        state <= DROP;
                end
                DROP: begin
                    if (drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                    count    <= '0;
                    word_idx <= '0;
                    last     <= 1'b0;
                    word     <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_ddr_writer.sv
// Directed bench for packet_ddr_writer: a DDR write responder with programmable ack
// latency logs every write, and each frame's log is compared with a packing model.
module tb_packet_ddr_writer;

    localparam logic [24:0] BASE = 25'd16;

    logic          clk_original = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    ff_rx_data = '0;
    logic          ff_rx_dval = 1'b0;
    logic          ff_rx_sop = 1'b0;
    logic          ff_rx_eop = 1'b0;
    logic          ff_rx_err = 1'b0;
    logic          ff_rx_rdy;
    logic [24:0]   ram_address;
    logic [255:0]  ram_wdata;
    logic          ram_wren;
    logic          ram_ack = 1'b0;
    logic          cmd_send;
    logic [24:0]   start_ram_addr;
    logic [15:0]   pkt_count;
    logic [15:0]   drop_count;

    packet_ddr_writer dut (
        .clk_original   (clk_original),
        .rst            (rst),
        .ff_rx_data     (ff_rx_data),
        .ff_rx_dval     (ff_rx_dval),
        .ff_rx_sop      (ff_rx_sop),
        .ff_rx_eop      (ff_rx_eop),
        .ff_rx_err      (ff_rx_err),
        .ff_rx_rdy      (ff_rx_rdy),
        .ram_address    (ram_address),
        .ram_wdata      (ram_wdata),
        .ram_wren       (ram_wren),
        .ram_ack        (ram_ack),
        .cmd_send       (cmd_send),
        .start_ram_addr (start_ram_addr),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    always #5 clk_original = ~clk_original;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [24:0]   wr_addr_q[$];
    logic [255:0]  wr_data_q[$];
    int            ack_delay = 0;
    int            wait_cnt = 0;
    int            send_cnt = 0;
    int            long_pulse = 0;
    logic          prev_cmd = 1'b0;
    bit            check_stable = 1'b0;
    logic [24:0]   hold_addr = '0;
    logic [255:0]  hold_data = '0;

    // DDR responder and cmd_send monitor, all on the falling edge.
    always @(negedge clk_original) begin
        if (rst) begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
            prev_cmd = 1'b0;
        end else begin
            if (cmd_send) begin
                send_cnt++;
                if (prev_cmd) long_pulse++;
            end
            prev_cmd = cmd_send;
            if (ram_wren) begin
                if (wait_cnt == 0) begin
                    hold_addr = ram_address;
                    hold_data = ram_wdata;
                end else if (check_stable) begin
                    check("wait_addr", ram_address, hold_addr);
                    check("wait_data", ram_wdata, hold_data);
                    check("wait_rdy", ff_rx_rdy, 1'b0);
                end
                ram_ack = (wait_cnt >= ack_delay);
                if (ram_ack) begin
                    wr_addr_q.push_back(ram_address);
                    wr_data_q.push_back(ram_wdata);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                ram_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    function automatic logic [255:0] exp_word(input int len, input logic [7:0] first, input int j);
        logic [255:0] w = '0;
        logic [7:0]   b;
        for (int k = 0; k < 32; k++) begin
            if (j * 32 + k < len) begin
                b = first + 8'(j * 32 + k);
                w[(k / 4) * 32 + 31 - (k % 4) * 8 -: 8] = b;
            end
        end
        return w;
    endfunction

    // Called at a falling edge; returns at the falling edge after the last byte is taken.
    task automatic send_frame(input int len, input logic [7:0] first, input logic err_on_eop);
        int  budget;
        bit  timed_out = 1'b0;
        for (int i = 0; i < len && !timed_out; i++) begin
            ff_rx_data = first + 8'(i);
            ff_rx_dval = 1'b1;
            ff_rx_sop  = (i == 0);
            ff_rx_eop  = (i == len - 1);
            ff_rx_err  = err_on_eop && (i == len - 1);
            budget = 0;
            while (!ff_rx_rdy && !timed_out) begin
                @(negedge clk_original);
                budget++;
                if (budget > 5000) begin
                    check("rdy_timeout", 1'b0, 1'b1);
                    timed_out = 1'b1;
                end
            end
            if (!timed_out) begin
                @(posedge clk_original);
                @(negedge clk_original);
            end
        end
        ff_rx_dval = 1'b0;
        ff_rx_sop  = 1'b0;
        ff_rx_eop  = 1'b0;
        ff_rx_err  = 1'b0;
    endtask

    task automatic wait_send(input int exp, input int budget);
        int b = 0;
        while (send_cnt < exp && b < budget) begin
            @(negedge clk_original);
            b++;
        end
        check("send_cnt", send_cnt, exp);
    endtask

    task automatic expect_frame(input string tag, input int len, input logic [7:0] first,
                                input int nwords, input bit has_len);
        int total = nwords + (has_len ? 1 : 0);
        check({tag, "_nwr"}, wr_addr_q.size(), total);
        for (int j = 0; j < nwords && j < wr_addr_q.size(); j++) begin
            check({tag, "_addr"}, wr_addr_q[j], BASE + 25'd1 + 25'(j));
            check({tag, "_data"}, wr_data_q[j], exp_word(len, first, j));
        end
        if (has_len && wr_addr_q.size() == total) begin
            check({tag, "_len_addr"}, wr_addr_q[total - 1], BASE);
            check({tag, "_len_data"}, wr_data_q[total - 1], 256'(len));
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk_original);
        check("rst_rdy", ff_rx_rdy, 1'b0);
        check("rst_wren", ram_wren, 1'b0);
        check("rst_addr", ram_address, 25'd0);
        check("rst_wdata", ram_wdata, 256'd0);
        check("rst_cmd", cmd_send, 1'b0);
        check("rst_pkt", pkt_count, 16'd0);
        check("rst_drop", drop_count, 16'd0);
        check("start_addr", start_ram_addr, BASE);
        rst = 1'b0;
        @(negedge clk_original);
        check("idle_rdy", ff_rx_rdy, 1'b1);

        // 64-byte frame, immediate ack
        clear_log();
        send_frame(64, 8'h00, 1'b0);
        wait_send(1, 300);
        @(negedge clk_original);
        check("t1_pkt", pkt_count, 16'd1);
        expect_frame("t1", 64, 8'h00, 2, 1'b1);
        check("t1_w0_lo", wr_data_q[0][31:0], 32'h00010203);
        check("t1_w0_hi", wr_data_q[0][255:224], 32'h1C1D1E1F);

        // single-byte frame
        clear_log();
        send_frame(1, 8'hAB, 1'b0);
        wait_send(2, 3000);
        expect_frame("t2", 1, 8'hAB, 1, 1'b1);
        check("t2_word", wr_data_q[0], {224'd0, 32'hAB00_0000});

        // maximum frame, then one byte too long
        clear_log();
        send_frame(255, 8'h00, 1'b0);
        wait_send(3, 3000);
        @(negedge clk_original);
        check("t3_pkt", pkt_count, 16'd3);
        expect_frame("t3", 255, 8'h00, 8, 1'b1);
        clear_log();
        send_frame(256, 8'h00, 1'b0);
        repeat (5) @(negedge clk_original);
        check("t3b_drop", drop_count, 16'd1);
        check("t3b_send", send_cnt, 3);
        expect_frame("t3b", 256, 8'h00, 7, 1'b0);

        // errored frame
        clear_log();
        send_frame(40, 8'h40, 1'b1);
        repeat (10) @(negedge clk_original);
        expect_frame("t4", 40, 8'h40, 1, 1'b0);
        check("t4_drop", drop_count, 16'd2);
        check("t4_send", send_cnt, 3);

        // slow DDR
        clear_log();
        ack_delay = 5;
        check_stable = 1'b1;
        send_frame(100, 8'h10, 1'b0);
        wait_send(4, 3000);
        check_stable = 1'b0;
        ack_delay = 0;
        expect_frame("t5", 100, 8'h10, 4, 1'b1);

        // reset in WR_DATA, then a clean frame
        clear_log();
        ack_delay = 1000;
        send_frame(32, 8'h80, 1'b0);
        repeat (3) @(negedge clk_original);
        check("t6_in_wr", ram_wren, 1'b1);
        s0 = send_cnt;
        rst = 1'b1;
        @(negedge clk_original);
        check("t6_rst_wren", ram_wren, 1'b0);
        check("t6_rst_addr", ram_address, 25'd0);
        check("t6_rst_wdata", ram_wdata, 256'd0);
        check("t6_rst_cmd", cmd_send, 1'b0);
        check("t6_rst_pkt", pkt_count, 16'd0);
        check("t6_rst_drop", drop_count, 16'd0);
        check("t6_rst_rdy", ff_rx_rdy, 1'b0);
        rst = 1'b0;
        ack_delay = 0;
        @(negedge clk_original);
        check("t6_no_send", send_cnt, s0);
        clear_log();
        send_frame(10, 8'hC0, 1'b0);
        wait_send(s0 + 1, 300);
        expect_frame("t6", 10, 8'hC0, 1, 1'b1);
        @(negedge clk_original);
        check("t6_pkt", pkt_count, 16'd1);
        repeat (3) @(negedge clk_original);
        ff_rx_data = 8'h55;
        ff_rx_dval = 1'b1;
        ff_rx_sop  = 1'b1;
        ff_rx_eop  = 1'b1;
        @(negedge clk_original);
        check("t6_hold_rdy", ff_rx_rdy, 1'b0);
        repeat (20) @(negedge clk_original);
        ff_rx_dval = 1'b0;
        ff_rx_sop  = 1'b0;
        ff_rx_eop  = 1'b0;
        check("t6_hold_nowr", wr_addr_q.size(), 2);
        check("t6_one_send", send_cnt, s0 + 1);
        check("cmd_width", long_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
